// File: rtl/cpu_controller_fsm.sv
// Multi-cycle control FSM with instruction register. It decodes one 16-bit instruction
// and sequences the regfile/ALU datapath enables, selects and operation codes.
module cpu_controller_fsm #(
  parameter int IR_W   = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IR_W-1:0]   in,
  input  logic              load,
  input  logic              s,
  output logic              w,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm8
);

  // state     | meaning
  // WAIT      | idle, w=1, IR loadable, s starts execution
  // DECODE    | classify IR, pick the first datapath step
  // WRITE_IMM | write sximm8 into Rn
  // GET_A     | read Rn into A
  // GET_B     | read Rm into B
  // EXEC      | ALU/shifter result into C, or flags into status for CMP
  // WRITE_REG | write C into Rd
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] alu_op;
  } ctl_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  state_t          state;
  state_t          state_nxt;
  logic [IR_W-1:0] ir;
  ctl_t            ctl_q;

  function automatic state_t next_state(input state_t st, input logic go,
                                        input logic [IR_W-1:0] instr);
    state_t nx;
    nx = S_WAIT;
    case (st)
      S_WAIT:   nx = go ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (instr[15:13] == OPC_MOV && instr[12:11] == 2'b10)      nx = S_WRITE_IMM;
        else if (instr[15:13] == OPC_MOV && instr[12:11] == 2'b00) nx = S_GET_B;
        else if (instr[15:13] == OPC_ALU)                          nx = S_GET_A;
        else                                                       nx = S_WAIT;
      end
      S_WRITE_IMM: nx = S_WAIT;
      S_GET_A:     nx = S_GET_B;
      S_GET_B:     nx = S_EXEC;
      S_EXEC:      nx = (instr[15:13] == OPC_ALU && instr[12:11] == 2'b01) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: nx = S_WAIT;
      default:     nx = S_WAIT;
    endcase
    return nx;
  endfunction

  // Moore output table; evaluated for the state being entered so outputs come from flops.
  function automatic ctl_t ctl_for(input state_t st, input logic [IR_W-1:0] instr);
    ctl_t c;
    c = '0;
    case (st)
      S_WAIT: c.w = 1'b1;
      S_WRITE_IMM: begin
        c.writenum = instr[10:8];
        c.vsel     = 2'b01;
        c.write    = 1'b1;
      end
      S_GET_A: begin
        c.readnum = instr[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = instr[2:0];
        c.loadb   = 1'b1;
      end
      S_EXEC: begin
        c.shift = instr[4:3];
        if (instr[15:13] == OPC_MOV) begin
          c.asel  = 1'b1;
          c.loadc = 1'b1;
        end else begin
          c.alu_op = instr[12:11];
          if (instr[12:11] == 2'b01) c.loads = 1'b1;
          else                       c.loadc = 1'b1;
        end
      end
      S_WRITE_REG: begin
        c.writenum = instr[7:5];
        c.write    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb state_nxt = next_state(state, s, ir);

  // IR only changes in WAIT, where the entered state's outputs never depend on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
      ctl_q <= ctl_for(S_WAIT, '0);
    end else begin
      if (state == S_WAIT && load) ir <= in;
      state <= state_nxt;
      ctl_q <= ctl_for(state_nxt, ir);
    end
  end

  assign w        = ctl_q.w;
  assign readnum  = ctl_q.readnum;
  assign writenum = ctl_q.writenum;
  assign write    = ctl_q.write & ~reset;
  assign loada    = ctl_q.loada & ~reset;
  assign loadb    = ctl_q.loadb & ~reset;
  assign loadc    = ctl_q.loadc & ~reset;
  assign loads    = ctl_q.loads & ~reset;
  assign asel     = ctl_q.asel;
  assign bsel     = 1'b0;
  assign vsel     = ctl_q.vsel;
  assign shift    = ctl_q.shift;
  assign ALUop    = ctl_q.alu_op;
  assign sximm8   = {{(DATA_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_cpu_controller_fsm.sv
// Directed bench for cpu_controller_fsm: the driver queues the expected output vector for
// each cycle it drives, and a negedge monitor pops and compares against the DUT.
module tb_cpu_controller_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic        s = 1'b0;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8;

  cpu_controller_fsm #(.IR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] exp;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  failures = 0;

  function automatic logic [35:0] ex(input logic ew, input logic [2:0] rn, input logic [2:0] wn,
                                     input logic wr, input logic la, input logic lb,
                                     input logic lc, input logic ls, input logic as,
                                     input logic [1:0] vs, input logic [1:0] sh,
                                     input logic [1:0] alu, input logic [15:0] sx);
    return {ew, rn, wn, wr, la, lb, lc, ls, as, 1'b0, vs, sh, alu, sx};
  endfunction

  function automatic logic [35:0] idle(input logic [15:0] sx);
    return ex(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, sx);
  endfunction

  function automatic logic [35:0] busy(input logic [15:0] sx);
    return ex(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, sx);
  endfunction

  // Inputs for the coming edge; e is what the outputs must show during this cycle.
  task automatic step(input logic [15:0] i_in, input logic i_load, input logic i_s,
                      input logic i_rst, input logic [35:0] e, input string tag,
                      input bit chk = 1'b1);
    sb_t item;
    @(posedge clk);
    #1;
    in    = i_in;
    load  = i_load;
    s     = i_s;
    reset = i_rst;
    if (chk) begin
      item.exp = e;
      item.tag = tag;
      sb.push_back(item);
    end
  endtask

  initial begin : monitor
    sb_t         item;
    logic [35:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        item = sb.pop_front();
        act = {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel,
               vsel, shift, ALUop, sximm8};
        checks++;
        if (act !== item.exp) begin
          failures++;
          $display("FAIL %s: got w=%b rn=%0d wn=%0d wr=%b la=%b lb=%b lc=%b ls=%b asel=%b bsel=%b vsel=%b sh=%b alu=%b sx=%h, expected vector %h got %h",
                   item.tag, w, readnum, writenum, write, loada, loadb, loadc, loads,
                   asel, bsel, vsel, shift, ALUop, sximm8, item.exp, act);
        end
      end
    end
  end

  initial begin : driver
    step(16'h0000, 0, 0, 1, '0, "pre_reset", 1'b0);
    step(16'h0000, 0, 0, 1, idle(16'h0000), "reset_state");
    // MOV R0,#7
    step(16'hD007, 1, 1, 0, idle(16'h0000), "t1_wait");
    step(16'h0000, 0, 0, 0, busy(16'h0007), "t1_decode");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd0,1,0,0,0,0,0,2'b01,2'b00,2'b00,16'h0007), "t1_write_imm");
    // MOV R1,#-2
    step(16'hD1FE, 1, 1, 0, idle(16'h0007), "t2_wait");
    step(16'h0000, 0, 0, 0, busy(16'hFFFE), "t2_decode");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd1,1,0,0,0,0,0,2'b01,2'b00,2'b00,16'hFFFE), "t2_write_imm");
    // load without s stays in WAIT
    step(16'hD005, 1, 0, 0, idle(16'hFFFE), "load_no_s");
    step(16'h0000, 0, 0, 0, idle(16'h0005), "load_no_s_idle");
    // ADD R2,R1,R0,LSL#1 with a load attempt in GET_A
    step(16'hA148, 1, 1, 0, idle(16'h0005), "t3_wait");
    step(16'h0000, 0, 0, 0, busy(16'h0048), "t3_decode");
    step(16'h00FF, 1, 0, 0, ex(0,3'd1,3'd0,0,1,0,0,0,0,2'b00,2'b00,2'b00,16'h0048), "t3_get_a");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd0,0,0,1,0,0,0,2'b00,2'b00,2'b00,16'h0048), "t3_get_b_ir_kept");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd0,0,0,0,1,0,0,2'b00,2'b01,2'b00,16'h0048), "t3_exec");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd2,1,0,0,0,0,0,2'b00,2'b00,2'b00,16'h0048), "t3_write_reg");
    // CMP R1,R0
    step(16'hA900, 1, 1, 0, idle(16'h0048), "t4_wait");
    step(16'h0000, 0, 0, 0, busy(16'h0000), "t4_decode");
    step(16'h0000, 0, 0, 0, ex(0,3'd1,3'd0,0,1,0,0,0,0,2'b00,2'b00,2'b00,16'h0000), "t4_get_a");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd0,0,0,1,0,0,0,2'b00,2'b00,2'b00,16'h0000), "t4_get_b");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd0,0,0,0,0,1,0,2'b00,2'b00,2'b01,16'h0000), "t4_exec_cmp");
    // undefined opcode
    step(16'hE000, 1, 1, 0, idle(16'h0000), "t5_wait");
    step(16'h0000, 0, 0, 0, busy(16'h0000), "t5_decode");
    // MOV R3,R5,LSR#1
    step(16'hC075, 1, 1, 0, idle(16'h0000), "t5_back_to_wait");
    step(16'h0000, 0, 0, 0, busy(16'h0075), "movr_decode");
    step(16'h0000, 0, 0, 0, ex(0,3'd5,3'd0,0,0,1,0,0,0,2'b00,2'b00,2'b00,16'h0075), "movr_get_b");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd0,0,0,0,1,0,1,2'b00,2'b10,2'b00,16'h0075), "movr_exec");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd3,1,0,0,0,0,0,2'b00,2'b00,2'b00,16'h0075), "movr_write_reg");
    // AND R7,R2,R3
    step(16'hB2E3, 1, 1, 0, idle(16'h0075), "and_wait");
    step(16'h0000, 0, 0, 0, busy(16'hFFE3), "and_decode");
    step(16'h0000, 0, 0, 0, ex(0,3'd2,3'd0,0,1,0,0,0,0,2'b00,2'b00,2'b00,16'hFFE3), "and_get_a");
    step(16'h0000, 0, 0, 0, ex(0,3'd3,3'd0,0,0,1,0,0,0,2'b00,2'b00,2'b00,16'hFFE3), "and_get_b");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd0,0,0,0,1,0,0,2'b00,2'b00,2'b10,16'hFFE3), "and_exec");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd7,1,0,0,0,0,0,2'b00,2'b00,2'b00,16'hFFE3), "and_write_reg");
    // ADD interrupted by reset during EXEC
    step(16'hA148, 1, 1, 0, idle(16'hFFE3), "t6_wait");
    step(16'h0000, 0, 0, 0, busy(16'h0048), "t6_decode");
    step(16'h0000, 0, 0, 0, ex(0,3'd1,3'd0,0,1,0,0,0,0,2'b00,2'b00,2'b00,16'h0048), "t6_get_a");
    step(16'h0000, 0, 0, 0, ex(0,3'd0,3'd0,0,0,1,0,0,0,2'b00,2'b00,2'b00,16'h0048), "t6_get_b");
    step(16'h0000, 0, 0, 1, ex(0,3'd0,3'd0,0,0,0,0,0,0,2'b00,2'b01,2'b00,16'h0048), "t6_exec_reset_masked");
    step(16'h0000, 0, 0, 0, idle(16'h0000), "t6_after_reset");
    // MOV imm interrupted by reset in WRITE_IMM: write must drop at once
    step(16'hD1FE, 1, 1, 0, idle(16'h0000), "rst_imm_wait");
    step(16'h0000, 0, 0, 0, busy(16'hFFFE), "rst_imm_decode");
    step(16'h0000, 0, 0, 1, ex(0,3'd0,3'd1,0,0,0,0,0,0,2'b01,2'b00,2'b00,16'hFFFE), "rst_imm_write_masked");
    step(16'h0000, 0, 0, 0, idle(16'h0000), "rst_imm_after");

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
